// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU behind a valid/ready input port.
// Each accepted operation is computed combinationally and registered into a
// 2-entry skid buffer (main + skid) that feeds a valid/ready result port.
// Also keeps a saturating completed-transfer counter and a sticky flag that
// records any accepted unrecognised control code.
module alu_exec_stage #(
    parameter int XLEN = 32,
    parameter int TAGW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_ctrl,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic [TAGW-1:0] out_tag,
    output logic [CNTW-1:0] op_count,
    output logic            err_sticky,
    input  logic            err_clear
);

    // ALU control codes as emitted by the core's ALU decoder.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Buffer entry state: main drives the outputs, skid catches one extra result.
    logic            main_valid_reg, main_valid_next;
    logic [XLEN-1:0] main_result_reg, main_result_next;
    logic            main_zero_reg, main_zero_next;
    logic            main_illegal_reg, main_illegal_next;
    logic [TAGW-1:0] main_tag_reg, main_tag_next;

    logic            skid_valid_reg, skid_valid_next;
    logic [XLEN-1:0] skid_result_reg, skid_result_next;
    logic            skid_zero_reg, skid_zero_next;
    logic            skid_illegal_reg, skid_illegal_next;
    logic [TAGW-1:0] skid_tag_reg, skid_tag_next;

    logic            in_ready_reg;
    logic [CNTW-1:0] op_count_reg;
    logic            err_sticky_reg;

    logic            in_fire;
    logic            out_fire;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            alu_zero;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = main_valid_reg & out_ready;

    // ALU datapath: decode the control code and compute the raw result.
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (in_ctrl)
            ALU_ADD: alu_result = in_a + in_b;
            ALU_SUB: alu_result = in_a - in_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_OR:  alu_result = in_a | in_b;
            ALU_AND: alu_result = in_a & in_b;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Zero flag is captured with the result so the output never recomputes it.
    assign alu_zero = (alu_result == '0);

    // Skid-buffer next-state: keep FIFO order, refill main from skid first.
    always_comb begin
        main_valid_next   = main_valid_reg;
        main_result_next  = main_result_reg;
        main_zero_next    = main_zero_reg;
        main_illegal_next = main_illegal_reg;
        main_tag_next     = main_tag_reg;
        skid_valid_next   = skid_valid_reg;
        skid_result_next  = skid_result_reg;
        skid_zero_next    = skid_zero_reg;
        skid_illegal_next = skid_illegal_reg;
        skid_tag_next     = skid_tag_reg;

        if (!main_valid_reg || out_fire) begin
            if (skid_valid_reg) begin
                // Skid is older than anything arriving now (in_ready is low).
                main_valid_next   = 1'b1;
                main_result_next  = skid_result_reg;
                main_zero_next    = skid_zero_reg;
                main_illegal_next = skid_illegal_reg;
                main_tag_next     = skid_tag_reg;
                skid_valid_next   = 1'b0;
            end else if (in_fire) begin
                main_valid_next   = 1'b1;
                main_result_next  = alu_result;
                main_zero_next    = alu_zero;
                main_illegal_next = alu_illegal;
                main_tag_next     = in_tag;
            end else begin
                // Payload fields hold their last value while empty.
                main_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            // Main is stalled: park the new result in the skid entry.
            skid_valid_next   = 1'b1;
            skid_result_next  = alu_result;
            skid_zero_next    = alu_zero;
            skid_illegal_next = alu_illegal;
            skid_tag_next     = in_tag;
        end
    end

    // Buffer registers; reset discards both entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg   <= 1'b0;
            main_result_reg  <= '0;
            main_zero_reg    <= 1'b0;
            main_illegal_reg <= 1'b0;
            main_tag_reg     <= '0;
            skid_valid_reg   <= 1'b0;
            skid_result_reg  <= '0;
            skid_zero_reg    <= 1'b0;
            skid_illegal_reg <= 1'b0;
            skid_tag_reg     <= '0;
            in_ready_reg     <= 1'b1;
        end else begin
            main_valid_reg   <= main_valid_next;
            main_result_reg  <= main_result_next;
            main_zero_reg    <= main_zero_next;
            main_illegal_reg <= main_illegal_next;
            main_tag_reg     <= main_tag_next;
            skid_valid_reg   <= skid_valid_next;
            skid_result_reg  <= skid_result_next;
            skid_zero_reg    <= skid_zero_next;
            skid_illegal_reg <= skid_illegal_next;
            skid_tag_reg     <= skid_tag_next;
            in_ready_reg     <= ~skid_valid_next;
        end
    end

    // Completed-transfer counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_reg <= '0;
        end else if (out_fire && (op_count_reg != {CNTW{1'b1}})) begin
            op_count_reg <= op_count_reg + CNTW'(1);
        end
    end

    // Sticky illegal-code flag; a new illegal acceptance beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_reg <= 1'b0;
        end else if (in_fire && alu_illegal) begin
            err_sticky_reg <= 1'b1;
        end else if (err_clear) begin
            err_sticky_reg <= 1'b0;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = main_valid_reg;
    assign out_result  = main_result_reg;
    assign out_zero    = main_zero_reg;
    assign out_illegal = main_illegal_reg;
    assign out_tag     = main_tag_reg;
    assign op_count    = op_count_reg;
    assign err_sticky  = err_sticky_reg;

endmodule
